keypad_event_queue: RTL and testbench
=====================================

KEYPAD_EVENT_QUEUE -- requirements
Module: keypad_event_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, event FIFO depth in entries (power of two, 2..16).
REQ-002 SHALL have port Clock  input  1  system clock; all state updates on posedge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port keys  input  16  debounced key-level bitmap from the 4x4 keypad scanner; bit i = key i held.
REQ-005 SHALL have port code  output  4  key index of the head event.
REQ-006 SHALL have port press  output  1  head event type: 1 = press, 0 = release.
REQ-007 SHALL have port valid  output  1  head event available.
REQ-008 SHALL have port ready  input  1  consumer accepts head event when valid && ready at posedge.
REQ-009 SHALL have port ovf  output  1  sticky overflow flag.

Function
REQ-010 SHALL register keys into keys_q each cycle and form rise = keys & ~keys_q, fall = ~keys & keys_q.
REQ-011 SHALL hold 16-bit pending masks pend_p and pend_r; each cycle, pend_p <= (pend_p & ~pop_p) | rise, and pend_r likewise with fall.
REQ-012 SHALL pop at most one pending bit per cycle, only when the FIFO is not full or a read occurs in the same cycle.
REQ-013 SHALL select the lowest-indexed set bit of pend_p first; only when pend_p is zero, the lowest-indexed set bit of pend_r.
REQ-014 SHALL write the popped {index, type} into the FIFO at the same edge it clears the pend bit.
REQ-015 SHALL give a latency of 2 edges from keys change to valid with the FIFO empty: keys_q and pend at edge k, FIFO write at edge k+1.
REQ-016 SHALL drive code and press from the FIFO head register and assert valid iff the FIFO is non-empty.
REQ-017 SHALL hold code, press and valid stable while valid && !ready.
REQ-018 SHALL support a simultaneous read and write on a full FIFO; occupancy is unchanged and no entry is lost.
REQ-019 SHALL keep pend bits set while the FIFO is full, deferring events rather than dropping them.
REQ-020 SHALL set ovf when a rise (fall) arrives for a bit already set in pend_p (pend_r); the events merge into one, and ovf stays set until reset.
REQ-021 SHALL treat a key released while its press is still pending as two independent pending events, emitting the press before the release.
REQ-022 SHALL use FIFO pointers of log2(DEPTH) bits, wrapping modulo DEPTH, plus a separate occupancy counter of log2(DEPTH)+1 bits.

Reset
REQ-023 SHALL, while Reset = 0 at posedge, clear keys_q, pend_p, pend_r, FIFO pointers and count, and ovf; valid = 0, code = 0, press = 0.
REQ-024 SHALL discard all queued and pending events on reset asserted mid-operation; keys held at reset release produce press events.

Configuration
REQ-025 SHALL recognise macro KEYPAD_RELEASE_EVENT_EN.
REQ-026 SHALL, when defined, generate release events per REQ-011..021.
REQ-027 SHALL, when undefined, omit pend_r and the FIFO type bit, never set ovf from fall, and tie press to 1.

Verification
REQ-028 SHALL cover: reset, keys=0x0000 then 0x0020, ready=1 -> valid high 2 edges later with code=5, press=1, then valid low.
REQ-029 SHALL cover: keys 0x0000 -> 0x8101 in one cycle, ready=1 -> codes 0, 8, 15 on consecutive cycles, all press=1.
REQ-030 SHALL cover: DEPTH=4, ready=0, 6 distinct presses -> 4 entries queued, valid held, code stable; ready=1 -> all 6 delivered in index order, ovf=0.
REQ-031 SHALL cover, with the macro defined: key 3 press then release, ready=1 -> (3,press=1) then (3,press=0); without the macro, only (3,1).
REQ-032 SHALL cover: ready=0, FIFO full, key 2 pressed, released and re-pressed (pend_p[2] set twice) -> ovf=1 and a single (2,1) event later; ovf persists until Reset=0.
REQ-033 SHALL cover: Reset=0 for one cycle with 3 events queued -> valid=0 next cycle and no stale event delivered.

Source files
------------

// File: rtl/keypad_event_queue.sv
// Keypad event queue: turns key-level edges into press/release events and
// buffers them in a FIFO. Define KEYPAD_RELEASE_EVENT_EN to also emit release events.
module keypad_event_queue #(
    parameter int DEPTH = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] keys,
    output logic [3:0]  code,
    output logic        press,
    output logic        valid,
    input  logic        ready,
    output logic        ovf
);
    localparam int AW = $clog2(DEPTH);
`ifdef KEYPAD_RELEASE_EVENT_EN
    localparam int EW = 5;
`else
    localparam int EW = 4;
`endif
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;

    logic [15:0]   keys_q, rise, pend_p, pop_p;
    logic [3:0]    idx_p;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] wdata, head;
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          rd, wr, full, can_pop;
`ifdef KEYPAD_RELEASE_EVENT_EN
    logic [15:0]   fall, pend_r, pop_r;
    logic [3:0]    idx_r;
`endif

    function automatic logic [3:0] lowest(input logic [15:0] m);
        lowest = 4'd0;
        for (int i = 15; i >= 0; i--)
            if (m[i]) lowest = 4'(i);
    endfunction

    assign rise    = keys & ~keys_q;
    assign idx_p   = lowest(pend_p);
    assign full    = (count == FULL_CNT);
    assign rd      = valid & ready;
    assign can_pop = !full || rd;
`ifdef KEYPAD_RELEASE_EVENT_EN
    assign fall    = ~keys & keys_q;
    assign idx_r   = lowest(pend_r);
`endif

    // Presses always win over releases so a quick tap reports press first.
    always_comb begin
        pop_p = '0;
        wr    = 1'b0;
        wdata = '0;
`ifdef KEYPAD_RELEASE_EVENT_EN
        pop_r = '0;
        if (can_pop) begin
            if (|pend_p) begin
                wr           = 1'b1;
                pop_p[idx_p] = 1'b1;
                wdata        = {1'b1, idx_p};
            end else if (|pend_r) begin
                wr           = 1'b1;
                pop_r[idx_r] = 1'b1;
                wdata        = {1'b0, idx_r};
            end
        end
`else
        if (can_pop && |pend_p) begin
            wr           = 1'b1;
            pop_p[idx_p] = 1'b1;
            wdata        = idx_p;
        end
`endif
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            keys_q <= '0;
            pend_p <= '0;
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            ovf    <= 1'b0;
`ifdef KEYPAD_RELEASE_EVENT_EN
            pend_r <= '0;
`endif
        end else begin
            keys_q <= keys;
            pend_p <= (pend_p & ~pop_p) | rise;
            // A second edge on a still-pending key merges into the first one.
            if (|(rise & pend_p & ~pop_p)) ovf <= 1'b1;
`ifdef KEYPAD_RELEASE_EVENT_EN
            pend_r <= (pend_r & ~pop_r) | fall;
            if (|(fall & pend_r & ~pop_r)) ovf <= 1'b1;
`endif
            if (wr) wptr <= wptr + PTR_ONE;
            if (rd) rptr <= rptr + PTR_ONE;
            case ({wr, rd})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset && wr) mem[wptr] <= wdata;
    end

    assign head  = mem[rptr];
    assign valid = (count != '0);
    assign code  = valid ? head[3:0] : 4'd0;
`ifdef KEYPAD_RELEASE_EVENT_EN
    assign press = valid & head[4];
`else
    assign press = 1'b1;
`endif
endmodule

// File: tb/tb_keypad_event_queue.sv
// Directed bench for keypad_event_queue (DEPTH=4), following both build
// configurations of the release-event option.
module tb_keypad_event_queue;
    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] keys  = '0;
    logic        ready = 1'b0;
    logic [3:0]  code;
    logic        press, valid, ovf;
    int          total = 0;
    int          bad   = 0;

    keypad_event_queue #(.DEPTH(4)) dut (
        .Clock(Clock), .Reset(Reset), .keys(keys), .code(code),
        .press(press), .valid(valid), .ready(ready), .ovf(ovf)
    );

    always #5 Clock = ~Clock;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        // reset state
        tick(2);
        check("rst_valid", 16'(valid), 16'd0);
        check("rst_code", 16'(code), 16'd0);
        check("rst_ovf", 16'(ovf), 16'd0);
`ifdef KEYPAD_RELEASE_EVENT_EN
        check("rst_press", 16'(press), 16'd0);
`else
        check("rst_press", 16'(press), 16'd1);
`endif
        Reset = 1'b1;
        tick(1);

        // single press, two-edge latency
        keys = 16'h0020; ready = 1'b1;
        tick(1);
        check("t1_lat1_valid", 16'(valid), 16'd0);
        tick(1);
        check("t1_valid", 16'(valid), 16'd1);
        check("t1_code", 16'(code), 16'd5);
        check("t1_press", 16'(press), 16'd1);
        tick(1);
        check("t1_empty", 16'(valid), 16'd0);
        keys = 16'h0000;
        tick(6);

        // three simultaneous presses, index order
        keys = 16'h8101;
        tick(2);
        check("t2_code0", 16'(code), 16'd0);
        check("t2_press0", 16'(press), 16'd1);
        tick(1);
        check("t2_code8", 16'(code), 16'd8);
        tick(1);
        check("t2_code15", 16'(code), 16'd15);
        check("t2_valid15", 16'(valid), 16'd1);
        tick(1);
        check("t2_empty", 16'(valid), 16'd0);
        keys = 16'h0000;
        tick(8);

        // six presses into a 4-deep FIFO with consumer stalled
        ready = 1'b0; keys = 16'h003F;
        tick(6);
        check("t3_valid_full", 16'(valid), 16'd1);
        check("t3_code_head", 16'(code), 16'd0);
        tick(3);
        check("t3_code_stable", 16'(code), 16'd0);
        check("t3_valid_stable", 16'(valid), 16'd1);
        ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            check($sformatf("t3_code%0d", i), 16'(code), 16'(i));
            check($sformatf("t3_valid%0d", i), 16'(valid), 16'd1);
        end
        tick(1);
        check("t3_empty", 16'(valid), 16'd0);
        check("t3_ovf", 16'(ovf), 16'd0);
        keys = 16'h0000;
        tick(16);

        // press then release of key 3
        keys = 16'h0008;
        tick(2);
        check("t4_code_p", 16'(code), 16'd3);
        check("t4_press_p", 16'(press), 16'd1);
        keys = 16'h0000;
        tick(1);
        check("t4_gap", 16'(valid), 16'd0);
        tick(1);
`ifdef KEYPAD_RELEASE_EVENT_EN
        check("t4_valid_r", 16'(valid), 16'd1);
        check("t4_code_r", 16'(code), 16'd3);
        check("t4_press_r", 16'(press), 16'd0);
`else
        check("t4_no_release", 16'(valid), 16'd0);
`endif
        tick(1);
        check("t4_empty", 16'(valid), 16'd0);

        // overflow: key 2 pressed twice while deferred behind a full FIFO
        ready = 1'b0; keys = 16'h00F0;
        tick(5);
        keys = 16'h00F4; tick(1);
        keys = 16'h00F0; tick(1);
        check("t5_ovf_pre", 16'(ovf), 16'd0);
        keys = 16'h00F4; tick(1);
        check("t5_ovf_set", 16'(ovf), 16'd1);
        check("t5_head4", 16'(code), 16'd4);
        ready = 1'b1;
        tick(3);
        check("t5_code7", 16'(code), 16'd7);
        tick(1);
        check("t5_code2", 16'(code), 16'd2);
        check("t5_press2", 16'(press), 16'd1);
        tick(1);
`ifdef KEYPAD_RELEASE_EVENT_EN
        check("t5_rel_valid", 16'(valid), 16'd1);
        check("t5_rel_code", 16'(code), 16'd2);
        check("t5_rel_press", 16'(press), 16'd0);
        tick(1);
`endif
        check("t5_single", 16'(valid), 16'd0);
        keys = 16'h0000;
        tick(12);
        check("t5_ovf_sticky", 16'(ovf), 16'd1);
        Reset = 1'b0; tick(1); Reset = 1'b1;
        check("t5_ovf_clr", 16'(ovf), 16'd0);
        tick(2);

        // reset mid-operation discards queued events
        ready = 1'b0; keys = 16'h0007;
        tick(4);
        check("t6_queued", 16'(valid), 16'd1);
        check("t6_head", 16'(code), 16'd0);
        Reset = 1'b0; keys = 16'h0000;
        tick(1);
        Reset = 1'b1;
        check("t6_valid_rst", 16'(valid), 16'd0);
        check("t6_code_rst", 16'(code), 16'd0);
        ready = 1'b1;
        tick(4);
        check("t6_no_stale", 16'(valid), 16'd0);

        // key held across reset is seen as a fresh press
        keys = 16'h0010;
        tick(3);
        Reset = 1'b0;
        tick(1);
        Reset = 1'b1;
        check("t7_rst_valid", 16'(valid), 16'd0);
        tick(2);
        check("t7_valid", 16'(valid), 16'd1);
        check("t7_code", 16'(code), 16'd4);
        check("t7_press", 16'(press), 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
